// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the default operand width.
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: d = x - y, br set when y exceeds x.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic br
);

    assign d  = x ^ y;
    assign br = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor: one result bit per clock, built from two
// half subtractors and a borrow flop, with a start/busy/done handshake.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             d1, br1, d, br2, bout;
    logic             last, accept;

    half_subtractor hs1 (.x(a_sr[0]), .y(b_sr[0]), .d(d1), .br(br1));
    half_subtractor hs2 (.x(d1),      .y(borrow),  .d(d),  .br(br2));

    assign bout   = br1 | br2;
    assign last   = (count == CW'(WIDTH - 1));
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
            diff   <= '0;
            b_out  <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            count  <= '0;
        end else if (state == SHIFT) begin
            // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= {d, res_sr[WIDTH-1:1]};
            borrow <= bout;
            count  <= count + CW'(1);
            if (last) begin
                diff  <= {d, res_sr[WIDTH-1:1]};
                b_out <= bout;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at WIDTH=8 and WIDTH=4,
// compared against plain (WIDTH+1)-bit arithmetic.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start4;
    logic [7:0] a8, b8, diff8;
    logic [3:0] a4, b4, diff4;
    logic       busy8, done8, bo8, busy4, done4, bo4;
    logic [7:0] last8;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .b_out(bo8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .b_out(bo4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Called at a negedge; leaves the bench at the negedge of the done cycle.
    // inj > 0 drives a spurious start with zero operands in that busy cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int inj);
        logic [8:0] exp;
        int cyc, nb;
        exp = {1'b0, a} - {1'b0, b};
        start8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; cyc = 1; nb = 0;
        while (!done8 && cyc <= 20) begin
            if (busy8) nb++;
            if (cyc == 2) chk("diff_hold", diff8, last8);
            a8 = 8'($urandom); b8 = 8'($urandom);
            if (cyc == inj) begin start8 = 1'b1; a8 = '0; b8 = '0; end
            else start8 = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        chk("done_cycle", cyc, 9);
        chk("busy_cycles", nb, 8);
        chk("busy_at_done", busy8, 0);
        chk("diff", diff8, exp[7:0]);
        chk("b_out", bo8, exp[8]);
        last8 = exp[7:0];
    endtask

    initial begin
        int cnt, cyc;
        logic [3:0] ta, tb;
        logic [4:0] e4;
        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0; last8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_bout", bo8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        op8(8'd5,   8'd3,   0); @(negedge clk);
        op8(8'd3,   8'd5,   0); @(negedge clk);
        op8(8'd0,   8'd1,   0); @(negedge clk);
        op8(8'hAA,  8'hAA,  0); @(negedge clk);
        op8(8'd100, 8'd1,   4); @(negedge clk);
        op8(8'd0,   8'hFF,  0); @(negedge clk);

        // Reset in the 3rd busy cycle aborts the op and clears the outputs.
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd7;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_diff", diff8, 0);
        chk("abort_bout", bo8, 0);
        rst_n = 1'b1; last8 = '0; cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) cnt++;
        end
        chk("no_done_after_rst", cnt, 0);

        // Back-to-back: the next op starts in the DONE cycle of the previous one.
        op8(8'd17, 8'd200, 0);
        op8(8'd250, 8'd9, 0);
        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 8'($urandom), 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // WIDTH=4 exhaustive, chained back-to-back.
        for (int i = 0; i < 256; i++) begin
            ta = 4'(i >> 4); tb = 4'(i);
            e4 = {1'b0, ta} - {1'b0, tb};
            start4 = 1'b1; a4 = ta; b4 = tb;
            @(negedge clk);
            start4 = 1'b0; cyc = 1;
            while (!done4 && cyc <= 10) begin
                a4 = 4'($urandom); b4 = 4'($urandom);
                @(negedge clk);
                cyc++;
            end
            chk("w4_latency", cyc, 5);
            chk("w4_result", {bo4, diff4}, e4);
        end
        chk("w4_idle_busy", busy4, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor that computes diff = a - b for WIDTH-bit unsigned operands at one bit per clock.
- Built from two half-subtractor cells per bit step. This is the subtract-direction counterpart of the combinational half-adder/full-adder blocks.
- Used where area matters more than latency.
- Start/busy/done handshake; results are held until the next accepted start.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  synchronous, active-low reset, sampled on rising clk
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend; captured on the accepted start edge only
b  input  WIDTH  subtrahend; captured on the accepted start edge only
busy  output  1  high while bits are being processed (SHIFT state)
done  output  1  single-cycle pulse; diff/b_out valid from this cycle on
diff  output  WIDTH  result a - b modulo 2^WIDTH
b_out  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, b_out = 0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → latch a and b into shift regs, borrow=0, count=0, go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT (busy=1):
  - Each edge computes one bit from the LSBs of the shift regs and the borrow flop.
  - Half-subtractor 1: d1 = x ^ y, br1 = ~x & y.
  - Half-subtractor 2: d = d1 ^ bin, br2 = ~d1 & bin.
  - bout = br1 | br2.
  - d shifts into the result register MSB-side; operand regs shift right; borrow <= bout; count++.
  - After WIDTH processed bits (count reaches WIDTH-1 at that edge): diff <= assembled result, b_out <= final borrow, go to DONE.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back ops) → SHIFT.
  - Otherwise → IDLE.
- Latency: start sampled at edge E0 → busy high cycles E0+1 .. E0+WIDTH → done high in cycle E0+WIDTH+1.
  - Throughput: one op per WIDTH+1 cycles.
- start while busy=1 is ignored: no restart, no queueing, and operands are not re-sampled.
- Changes on a/b after the accepted edge do not affect the result.
- diff and b_out:
  - Update only at the SHIFT→DONE transition.
  - Hold their values through IDLE and during the next operation until its DONE.
- Arithmetic: diff = (a - b) mod 2^WIDTH; {b_out, diff} equals the (WIDTH+1)-bit two's-complement result of a - b.
  - a == b → diff = 0, b_out = 0.
  - a = 0, b = 2^WIDTH-1 → diff = 1, b_out = 1.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package (arith_pkg):
  - State encoding constants: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - Default width constant ARITH_WIDTH = 8.
- Sub-module half_subtractor:
  - Inputs x, y; outputs d = x ^ y, br = ~x & y; purely combinational.
  - Instantiated twice in serial_subtractor to form the per-bit full subtractor.
- Counter width: $clog2(WIDTH).

Test Plan:
- WIDTH=8, a=8'd5, b=8'd3, start pulsed one cycle:
  - busy high 8 cycles.
  - done pulses in cycle 9 after the start edge.
  - diff=8'h02, b_out=0.
- a=8'd3, b=8'd5 → diff=8'hFE, b_out=1.
- a=0, b=1 → diff=8'hFF, b_out=1.
- a=8'hAA, b=8'hAA → diff=0, b_out=0.
- Started with a=8'd100, b=8'd1; on the 4th busy cycle drive start=1 with a=0, b=0:
  - Second start ignored.
  - diff=8'd99, b_out=0, done at the nominal cycle.
- Reset and back-to-back checks:
  - rst_n low on the 3rd busy cycle → next cycle busy=0, done=0, diff=0, b_out=0, no done pulse afterwards.
  - Then start asserted during a DONE cycle → new op accepted with no IDLE gap.
  - WIDTH=4 exhaustive 256 pairs checked against a reference model of {b_out, diff} = a - b.
